// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter slice.
package ram_arb_pkg;

  // Cycles from a read chip-select to valid read data on the RAM port.
  localparam int unsigned RAM_RD_LATENCY = 1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_op_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [idx_width(NUM_REQ)-1:0]   ptr,
  output logic [NUM_REQ-1:0]              grant,
  output logic [idx_width(NUM_REQ)-1:0]   idx
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // Modulo keeps the candidate in range when NUM_REQ is not a power of two.
      cand = IW'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sharing of one single-port synchronous RAM among NUM_REQ requesters,
// with registered RAM command outputs and a fixed two-cycle read response.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  typedef struct packed {
    cmd_op_e                 op;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
  } cmd_t;

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  cmd_t               sel_cmd;
  logic [IW-1:0]      cmd_idx;
  logic [NUM_REQ-1:0] rd_strobe;
  logic [NUM_REQ-1:0] rsp_pipe [RAM_RD_LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (grant_idx)
  );

  assign grant     = rst_n ? arb_grant : '0;
  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_cmd.op    = cmd_op_e'(req_we[grant_idx]);
    sel_cmd.addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_cmd.wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    rd_strobe = '0;
    if (ram_cs && !ram_we) rd_strobe[cmd_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cmd_idx   <= '0;
    end else if (accept) begin
      rr_ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      ram_cs    <= 1'b1;
      ram_we    <= (sel_cmd.op == CMD_WRITE);
      ram_addr  <= sel_cmd.addr;
      ram_wdata <= sel_cmd.wdata;
      cmd_idx   <= grant_idx;
    end else begin
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
    end
  end

  // Issuer strobe trails the read chip-select by the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < RAM_RD_LATENCY; k++) rsp_pipe[k] <= '0;
    end else begin
      rsp_pipe[0] <= rd_strobe;
      for (int unsigned k = 1; k < RAM_RD_LATENCY; k++) rsp_pipe[k] <= rsp_pipe[k-1];
    end
  end

  assign rsp_valid = rsp_pipe[RAM_RD_LATENCY-1];
  assign rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized checks of ram_arbiter against a behavioural RAM and scoreboard.
module tb_ram_arbiter;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [DW-1:0]      rsp_rdata, ram_wdata, ram_rdata;
  logic               ram_cs, ram_we;
  logic [AW-1:0]      ram_addr;

  logic [2:0]         v3, rdy3, we3, rsp3_v;
  logic [3*AW-1:0]    addr3;
  logic [3*DW-1:0]    wdata3;
  logic [DW-1:0]      rsp3_d, wd3o, rdata3;
  logic               cs3, we3o;
  logic [AW-1:0]      addr3o;

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
    .req_we(we3), .req_addr(addr3), .req_wdata(wdata3),
    .rsp_valid(rsp3_v), .rsp_rdata(rsp3_d), .ram_cs(cs3), .ram_we(we3o),
    .ram_addr(addr3o), .ram_wdata(wd3o), .ram_rdata(rdata3)
  );

  assign rdata3 = '0;

  // Single-port RAM with a one-cycle registered read.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } vec_t;

  vec_t tbl [14];

  logic [3:0]    h1, h2, acc, acc_prev, p1v, p2v, nv;
  logic [DW-1:0] p1d, p2d, nd;
  int            wt [NR];
  logic [2:0]    exp3 [4];

  initial begin
    // {valid, expected grant}; pointer starts at 0 after reset
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b0000, 4'b0000};
    tbl[5]  = '{4'b0100, 4'b0100};
    tbl[6]  = '{4'b0100, 4'b0100};
    tbl[7]  = '{4'b0011, 4'b0001};
    tbl[8]  = '{4'b1001, 4'b1000};
    tbl[9]  = '{4'b1001, 4'b0001};
    tbl[10] = '{4'b0110, 4'b0010};
    tbl[11] = '{4'b1000, 4'b1000};
    tbl[12] = '{4'b0000, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0000};
    exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b001;

    for (int a = 0; a < 16; a++) begin
      mem[a]     = 32'hA000_0000 | 32'(a);
      ref_mem[a] = 32'hA000_0000 | 32'(a);
    end

    rst_n = 1'b0; req_valid = '1; req_we = '0; req_wdata = '0;
    v3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(8 + i);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);

    // Idle after reset
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      chk("idle", {ram_cs, ram_we, rsp_valid, req_ready}, 0);
    end

    // Table-driven grant / response sequence, all reads
    h1 = '0; h2 = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      req_valid = tbl[k].valid;
      #1;
      chk("grant", req_ready, tbl[k].ready);
      chk("rsp_valid", rsp_valid, h2);
      if (h2 != 0) chk("rsp_rdata", rsp_rdata, 32'hA000_0000 | 32'(8 + onehot_idx(h2)));
      h2 = h1; h1 = tbl[k].ready;
    end

    // Write then read the same address from requester 2
    @(negedge clk);
    req_valid = 4'b0100; req_we = 4'b0100;
    req_addr[2*AW +: AW] = 4'd5; req_wdata[2*DW +: DW] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    #1; chk("wr_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_we = 4'b0000;
    #1;
    chk("wr_ram_cmd", {ram_cs, ram_we, ram_addr}, {1'b1, 1'b1, 4'd5});
    chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    chk("rd_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rd_ram_cmd", {ram_cs, ram_we, ram_addr}, {1'b1, 1'b0, 4'd5});
    chk("wr_no_rsp", rsp_valid, 0);
    @(negedge clk); #1;
    chk("raw_rsp_valid", rsp_valid, 4'b0100);
    chk("raw_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("raw_rsp_done", rsp_valid, 0);

    // Reset in the middle of a read (pointer is 3 here)
    @(negedge clk);
    req_valid = 4'b0010; req_addr[1*AW +: AW] = 4'd9;
    #1; chk("mid_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1111; rst_n = 1'b0;
    #1;
    chk("mid_ready_forced", req_ready, 0);
    chk("mid_cmd_on_bus", ram_cs, 1);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    #1;
    chk("mid_rsp_t2", rsp_valid, 0);
    chk("mid_cs_cleared", ram_cs, 0);
    @(negedge clk); #1;
    chk("mid_rsp_t3", rsp_valid, 0);
    @(negedge clk);
    req_valid = 4'b1111;
    #1; chk("mid_ptr_reset", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("post_rst_rsp_valid", rsp_valid, 4'b0001);
    chk("post_rst_rsp_rdata", rsp_rdata, ref_mem[8]);

    // Three-requester instance wraps 0,1,2,0
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v3 = 3'b111;
      #1; chk("nr3_grant", rdy3, exp3[k]);
    end
    @(negedge clk);
    v3 = '0;

    // Random mixed traffic against a reference memory
    acc_prev = '0; p1v = '0; p2v = '0; p1d = '0; p2d = '0;
    for (int i = 0; i < NR; i++) wt[i] = 0;
    repeat (2) @(negedge clk);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && !acc_prev[i])) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_we[i]    = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
          req_wdata[i*DW +: DW] = $urandom;
          wt[i] = 0;
        end
      end
      #1;
      chk("rnd_ready_legal",
          ((req_ready & ~req_valid) == 0) && ((req_ready & (req_ready - 4'd1)) == 0), 1);
      chk("rnd_rsp_valid", rsp_valid, p2v);
      if (p2v != 0) chk("rnd_rsp_rdata", rsp_rdata, p2d);
      acc = req_ready & req_valid;
      nv = '0; nd = '0;
      if (acc != 0) begin
        automatic int w = onehot_idx(acc);
        automatic logic [AW-1:0] a = req_addr[w*AW +: AW];
        if (req_we[w]) ref_mem[a] = req_wdata[w*DW +: DW];
        else begin
          nv = acc; nd = ref_mem[a];
        end
        chk("rnd_fairness", wt[w] > NR - 1, 0);
        for (int j = 0; j < NR; j++) if (j != w && req_valid[j]) wt[j]++;
        wt[w] = 0;
      end
      p2v = p1v; p2d = p1d; p1v = nv; p1d = nd;
      acc_prev = acc;
    end
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("drain_rsp_valid", rsp_valid, p2v);
      if (p2v != 0) chk("drain_rsp_rdata", rsp_rdata, p2d);
      p2v = p1v; p2d = p1d; p1v = '0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
